// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU issue controller: ALU control codes, MIPS
// opcode/funct encodings, FSM state encoding and the decoder's output bundle.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_NOR = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_e;
  typedef enum logic [1:0] {SEL_RS_RT, SEL_RT_SHAMT, SEL_RS_IMM} opsel_e;
  typedef enum logic [1:0] {BR_NONE, BR_EQ, BR_NE} branch_e;

  typedef struct packed {
    logic [3:0] ctrl;
    opsel_e     opSel;
    logic       signExt;
    logic       ovfEn;
    branch_e    branch;
    logic       illegal;
  } decode_t;

  function automatic logic [31:0] extendImm(input logic [15:0] imm, input logic signExt);
    return signExt ? {{16{imm[15]}}, imm} : {16'b0, imm};
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational {opcode, funct} decode to ALU control, operand select and response flags.
// I-type opcodes are only recognised when ALU_ISSUE_IMM_EN is defined.
module alu_op_decoder
  import alu_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output decode_t    dec_o
);

  // Anything not matched below falls through as illegal with the idle control code.
  always_comb begin
    dec_o = '{ctrl: ALU_NOP, opSel: SEL_RS_RT, signExt: 1'b0, ovfEn: 1'b0,
              branch: BR_NONE, illegal: 1'b1};
    case (opcode_i)
      OP_RTYPE: begin
        dec_o.illegal = 1'b0;
        case (funct_i)
          FN_ADD:  begin dec_o.ctrl = ALU_ADD; dec_o.ovfEn = 1'b1; end
          FN_ADDU: dec_o.ctrl = ALU_ADD;
          FN_SUB:  begin dec_o.ctrl = ALU_SUB; dec_o.ovfEn = 1'b1; end
          FN_SUBU: dec_o.ctrl = ALU_SUB;
          FN_AND:  dec_o.ctrl = ALU_AND;
          FN_OR:   dec_o.ctrl = ALU_OR;
          FN_XOR:  dec_o.ctrl = ALU_XOR;
          FN_NOR:  dec_o.ctrl = ALU_NOR;
          FN_SLT:  dec_o.ctrl = ALU_SLT;
          FN_SLL:  begin dec_o.ctrl = ALU_SLL; dec_o.opSel = SEL_RT_SHAMT; end
          FN_SRL:  begin dec_o.ctrl = ALU_SRL; dec_o.opSel = SEL_RT_SHAMT; end
          default: dec_o.illegal = 1'b1;
        endcase
      end
      OP_BEQ: begin
        dec_o.ctrl    = ALU_SUB;
        dec_o.branch  = BR_EQ;
        dec_o.illegal = 1'b0;
      end
      OP_BNE: begin
        dec_o.ctrl    = ALU_SUB;
        dec_o.branch  = BR_NE;
        dec_o.illegal = 1'b0;
      end
`ifdef ALU_ISSUE_IMM_EN
      OP_ADDI: begin
        dec_o = '{ctrl: ALU_ADD, opSel: SEL_RS_IMM, signExt: 1'b1, ovfEn: 1'b1,
                  branch: BR_NONE, illegal: 1'b0};
      end
      OP_SLTI: begin
        dec_o = '{ctrl: ALU_SLT, opSel: SEL_RS_IMM, signExt: 1'b1, ovfEn: 1'b0,
                  branch: BR_NONE, illegal: 1'b0};
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        dec_o.opSel   = SEL_RS_IMM;
        dec_o.illegal = 1'b0;
        dec_o.ctrl    = (opcode_i == OP_ANDI) ? ALU_AND :
                        (opcode_i == OP_ORI)  ? ALU_OR  : ALU_XOR;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue_controller.sv
// Execute-stage front end: accepts one decoded instruction, drives the ALU, captures its
// result and returns a registered response. Optional I-type support via ALU_ISSUE_IMM_EN.
module alu_issue_controller
  import alu_pkg::*;
#(
  parameter int ALU_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_opcode,
  input  logic [5:0]  in_funct,
  input  logic [4:0]  in_shamt,
  input  logic [15:0] in_imm,
  input  logic [31:0] in_rs_data,
  input  logic [31:0] in_rt_data,
  output logic [3:0]  alu_control,
  output logic [31:0] alu_operand0,
  output logic [31:0] alu_operand1,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_zero,
  output logic        out_overflow,
  output logic        out_branch,
  output logic        out_illegal
);

  localparam int CW = $clog2(ALU_LATENCY + 2);

  decode_t       dec;
  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    ctrl_q;
  logic [31:0]   op0_q, op1_q, op0_d, op1_d;
  logic          ovfEn_q, slt_q;
  branch_e       brType_q;
  logic [31:0]   result_q;
  logic          zero_q, ovf_q, branch_q, illegal_q;

  alu_op_decoder u_decoder (
    .opcode_i (in_opcode),
    .funct_i  (in_funct),
    .dec_o    (dec)
  );

  always_comb begin
    op0_d = in_rs_data;
    op1_d = in_rt_data;
    case (dec.opSel)
      SEL_RT_SHAMT: begin
        op0_d = in_rt_data;
        op1_d = {27'b0, in_shamt};
      end
      SEL_RS_IMM: op1_d = extendImm(in_imm, dec.signExt);
      default: ;
    endcase
  end

  // The ALU registers its outputs one edge after the control change, so the capture
  // waits ALU_LATENCY edges after that before reading the result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ctrl_q    <= ALU_NOP;
      op0_q     <= '0;
      op1_q     <= '0;
      ovfEn_q   <= 1'b0;
      slt_q     <= 1'b0;
      brType_q  <= BR_NONE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      branch_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            if (dec.illegal) begin
              result_q  <= '0;
              zero_q    <= 1'b0;
              ovf_q     <= 1'b0;
              branch_q  <= 1'b0;
              illegal_q <= 1'b1;
              state_q   <= ST_RESP;
            end else begin
              ctrl_q   <= dec.ctrl;
              op0_q    <= op0_d;
              op1_q    <= op1_d;
              ovfEn_q  <= dec.ovfEn;
              slt_q    <= (dec.ctrl == ALU_SLT);
              brType_q <= dec.branch;
              cnt_q    <= '0;
              state_q  <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          if (cnt_q == CW'(ALU_LATENCY)) begin
            result_q  <= slt_q ? {31'b0, |alu_result} : alu_result;
            zero_q    <= alu_zero;
            ovf_q     <= alu_overflow & ovfEn_q;
            branch_q  <= ((brType_q == BR_EQ) & alu_zero) | ((brType_q == BR_NE) & ~alu_zero);
            illegal_q <= 1'b0;
            ctrl_q    <= ALU_NOP;
            state_q   <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_RESP: begin
          if (out_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready     = (state_q == ST_IDLE);
  assign out_valid    = (state_q == ST_RESP);
  assign alu_control  = ctrl_q;
  assign alu_operand0 = op0_q;
  assign alu_operand1 = op1_q;
  assign out_result   = result_q;
  assign out_zero     = zero_q;
  assign out_overflow = ovf_q;
  assign out_branch   = branch_q;
  assign out_illegal  = illegal_q;

endmodule

// File: tb/tb_alu_issue_controller.sv
// Directed self-checking bench for alu_issue_controller with a registered ALU model.
// I-type expectations follow ALU_ISSUE_IMM_EN when the bench is compiled with it.
module tb_alu_issue_controller;

  localparam logic [3:0] NOP = 4'b1111;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_opcode = '0;
  logic [5:0]  in_funct = '0;
  logic [4:0]  in_shamt = '0;
  logic [15:0] in_imm = '0;
  logic [31:0] in_rs_data = '0;
  logic [31:0] in_rt_data = '0;
  logic [3:0]  alu_control;
  logic [31:0] alu_operand0, alu_operand1;
  logic [31:0] alu_result = '0;
  logic        alu_zero = 1'b0;
  logic        alu_overflow = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_zero, out_overflow, out_branch, out_illegal;

  int testsRun = 0;
  int failures = 0;

  alu_issue_controller dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_opcode    (in_opcode),
    .in_funct     (in_funct),
    .in_shamt     (in_shamt),
    .in_imm       (in_imm),
    .in_rs_data   (in_rs_data),
    .in_rt_data   (in_rt_data),
    .alu_control  (alu_control),
    .alu_operand0 (alu_operand0),
    .alu_operand1 (alu_operand1),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_zero     (out_zero),
    .out_overflow (out_overflow),
    .out_branch   (out_branch),
    .out_illegal  (out_illegal)
  );

  always #5 clock = ~clock;

  // Registered 32-bit ALU: updates on a clock edge unless idle, holds otherwise.
  function automatic logic [33:0] aluModel(input logic [3:0] c, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r;
    logic        v;
    r = '0;
    v = 1'b0;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      4'b0011: r = a ^ b;
      4'b0100: r = ~(a | b);
      4'b0110: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      4'b0111: r = {31'b0, $signed(a) < $signed(b)};
      4'b1000: r = a << b[4:0];
      4'b1001: r = a >> b[4:0];
      default: r = '0;
    endcase
    return {v, r == 32'd0, r};
  endfunction

  always @(posedge clock) begin
    if (alu_control != NOP)
      {alu_overflow, alu_zero, alu_result} <= aluModel(alu_control, alu_operand0, alu_operand1);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Issue one instruction from IDLE and wait (bounded) for the response to appear.
  task automatic applyStimulus(input string tag, input logic [5:0] op, input logic [5:0] fn,
                               input logic [4:0] sh, input logic [15:0] imm,
                               input logic [31:0] rs, input logic [31:0] rt, input logic legal,
                               input logic [3:0] expCtrl, input logic [31:0] expOp0,
                               input logic [31:0] expOp1);
    int lat;
    checkOutput({tag, ".in_ready"}, {31'b0, in_ready}, 32'd1);
    in_opcode  = op;
    in_funct   = fn;
    in_shamt   = sh;
    in_imm     = imm;
    in_rs_data = rs;
    in_rt_data = rt;
    in_valid   = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    if (legal) begin
      checkOutput({tag, ".alu_control"}, {28'b0, alu_control}, {28'b0, expCtrl});
      checkOutput({tag, ".op0"}, alu_operand0, expOp0);
      checkOutput({tag, ".op1"}, alu_operand1, expOp1);
    end else begin
      checkOutput({tag, ".alu_control_nop"}, {28'b0, alu_control}, {28'b0, NOP});
    end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clock);
      #1;
      lat++;
    end
    checkOutput({tag, ".latency"}, lat, legal ? 32'd2 : 32'd0);
  endtask

  task automatic checkResponse(input string tag, input logic [31:0] res, input logic z,
                               input logic ovf, input logic br, input logic ill);
    checkOutput({tag, ".result"}, out_result, res);
    checkOutput({tag, ".zero"}, {31'b0, out_zero}, {31'b0, z});
    checkOutput({tag, ".overflow"}, {31'b0, out_overflow}, {31'b0, ovf});
    checkOutput({tag, ".branch"}, {31'b0, out_branch}, {31'b0, br});
    checkOutput({tag, ".illegal"}, {31'b0, out_illegal}, {31'b0, ill});
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    checkOutput({tag, ".valid_drop"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst.out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst.alu_control", {28'b0, alu_control}, {28'b0, NOP});
    checkOutput("rst.out_result", out_result, 32'd0);
    checkOutput("rst.op0", alu_operand0, 32'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    applyStimulus("add", 6'b000000, 6'b100000, 5'd0, 16'd0, 32'd7, 32'd5, 1'b1, 4'b0010, 32'd7, 32'd5);
    checkResponse("add", 32'd12, 1'b0, 1'b0, 1'b0, 1'b0);

    applyStimulus("beq", 6'b000100, 6'b000000, 5'd0, 16'd0, 32'hA5, 32'hA5, 1'b1, 4'b0110, 32'hA5, 32'hA5);
    checkResponse("beq", 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus("bne", 6'b000101, 6'b000000, 5'd0, 16'd0, 32'hA5, 32'hA5, 1'b1, 4'b0110, 32'hA5, 32'hA5);
    checkResponse("bne", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus("bne_taken", 6'b000101, 6'b000000, 5'd0, 16'd0, 32'd9, 32'd4, 1'b1, 4'b0110, 32'd9, 32'd4);
    checkResponse("bne_taken", 32'd5, 1'b0, 1'b0, 1'b1, 1'b0);

    applyStimulus("sll", 6'b000000, 6'b000000, 5'd4, 16'd0, 32'hDEADBEEF, 32'd1, 1'b1, 4'b1000, 32'd1, 32'd4);
    checkResponse("sll", 32'd16, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("srl", 6'b000000, 6'b000010, 5'd3, 16'd0, 32'd0, 32'h80, 1'b1, 4'b1001, 32'h80, 32'd3);
    checkResponse("srl", 32'h10, 1'b0, 1'b0, 1'b0, 1'b0);

    applyStimulus("slt_3_9", 6'b000000, 6'b101010, 5'd0, 16'd0, 32'd3, 32'd9, 1'b1, 4'b0111, 32'd3, 32'd9);
    checkResponse("slt_3_9", 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("slt_neg", 6'b000000, 6'b101010, 5'd0, 16'd0, 32'hFFFFFFFF, 32'd2, 1'b1, 4'b0111, 32'hFFFFFFFF, 32'd2);
    checkResponse("slt_neg", 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("slt_9_3", 6'b000000, 6'b101010, 5'd0, 16'd0, 32'd9, 32'd3, 1'b1, 4'b0111, 32'd9, 32'd3);
    checkResponse("slt_9_3", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    applyStimulus("add_ovf", 6'b000000, 6'b100000, 5'd0, 16'd0, 32'h7FFFFFFF, 32'd1, 1'b1, 4'b0010, 32'h7FFFFFFF, 32'd1);
    checkResponse("add_ovf", 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus("addu_ovf", 6'b000000, 6'b100001, 5'd0, 16'd0, 32'h7FFFFFFF, 32'd1, 1'b1, 4'b0010, 32'h7FFFFFFF, 32'd1);
    checkResponse("addu_ovf", 32'h80000000, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("sub_ovf", 6'b000000, 6'b100010, 5'd0, 16'd0, 32'h80000000, 32'd1, 1'b1, 4'b0110, 32'h80000000, 32'd1);
    checkResponse("sub_ovf", 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus("subu", 6'b000000, 6'b100011, 5'd0, 16'd0, 32'h80000000, 32'd1, 1'b1, 4'b0110, 32'h80000000, 32'd1);
    checkResponse("subu", 32'h7FFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0);

    applyStimulus("and", 6'b000000, 6'b100100, 5'd0, 16'd0, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b1, 4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0);
    checkResponse("and", 32'h00F000F0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("or", 6'b000000, 6'b100101, 5'd0, 16'd0, 32'h12000034, 32'h00005600, 1'b1, 4'b0001, 32'h12000034, 32'h00005600);
    checkResponse("or", 32'h12005634, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("xor", 6'b000000, 6'b100110, 5'd0, 16'd0, 32'hFFFF0000, 32'h0F0F0F0F, 1'b1, 4'b0011, 32'hFFFF0000, 32'h0F0F0F0F);
    checkResponse("xor", 32'hF0F00F0F, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("nor", 6'b000000, 6'b100111, 5'd0, 16'd0, 32'd0, 32'd0, 1'b1, 4'b0100, 32'd0, 32'd0);
    checkResponse("nor", 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0);

    applyStimulus("ill_funct", 6'b000000, 6'b111111, 5'd0, 16'd0, 32'd1, 32'd2, 1'b0, NOP, 32'd0, 32'd0);
    checkResponse("ill_funct", 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus("ill_opcode", 6'b111111, 6'b100000, 5'd0, 16'd0, 32'd1, 32'd2, 1'b0, NOP, 32'd0, 32'd0);
    checkResponse("ill_opcode", 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);

`ifdef ALU_ISSUE_IMM_EN
    applyStimulus("addi", 6'b001000, 6'b000000, 5'd0, 16'hFFFF, 32'd1, 32'd0, 1'b1, 4'b0010, 32'd1, 32'hFFFFFFFF);
    checkResponse("addi", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus("andi", 6'b001100, 6'b000000, 5'd0, 16'h8000, 32'hFFFFFFFF, 32'd0, 1'b1, 4'b0000, 32'hFFFFFFFF, 32'h00008000);
    checkResponse("andi", 32'h00008000, 1'b0, 1'b0, 1'b0, 1'b0);
`else
    applyStimulus("addi", 6'b001000, 6'b000000, 5'd0, 16'hFFFF, 32'd1, 32'd0, 1'b0, NOP, 32'd0, 32'd0);
    checkResponse("addi", 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus("andi", 6'b001100, 6'b000000, 5'd0, 16'h8000, 32'hFFFFFFFF, 32'd0, 1'b0, NOP, 32'd0, 32'd0);
    checkResponse("andi", 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

    applyStimulus("hold", 6'b000000, 6'b100000, 5'd0, 16'd0, 32'd7, 32'd5, 1'b1, 4'b0010, 32'd7, 32'd5);
    in_funct   = 6'b100010;
    in_rs_data = 32'd100;
    in_valid   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold.out_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("hold.out_result", out_result, 32'd12);
      checkOutput("hold.in_ready", {31'b0, in_ready}, 32'd0);
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    checkResponse("hold", 32'd12, 1'b0, 1'b0, 1'b0, 1'b0);

    checkOutput("rstx.in_ready", {31'b0, in_ready}, 32'd1);
    in_opcode  = 6'b000000;
    in_funct   = 6'b100000;
    in_rs_data = 32'd100;
    in_rt_data = 32'd200;
    in_valid   = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    checkOutput("rstx.exec_ctrl", {28'b0, alu_control}, 32'h2);
    reset = 1'b1;
    #1;
    checkOutput("rstx.out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rstx.alu_control", {28'b0, alu_control}, {28'b0, NOP});
    checkOutput("rstx.op0", alu_operand0, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("rstx.post_valid", {31'b0, out_valid}, 32'd0);
    applyStimulus("post_rst", 6'b000000, 6'b100000, 5'd0, 16'd0, 32'd2, 32'd3, 1'b1, 4'b0010, 32'd2, 32'd3);
    checkResponse("post_rst", 32'd5, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
